cbus_rr_arbiter: RTL
====================

CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2: number of upstream CBus requesters, legal range 2..8.
REQ-002 SHALL have parameter POLICY, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_INPUTS): owner index width; never overridden.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ireqs, input, cbus_req_t [NUM_INPUTS]: upstream requests; element i is requester i.
REQ-007 SHALL have port iresps, output, cbus_resp_t [NUM_INPUTS]: upstream responses.
REQ-008 SHALL have port oreq, output, cbus_req_t: downstream request to memory.
REQ-009 SHALL have port oresp, input, cbus_resp_t: downstream response.
REQ-010 SHALL have port busy, output, 1: high while a transaction is owned.
REQ-011 SHALL have port owner, output, IDX_W: index of the current owner; 0 when idle.

Function
REQ-012 SHALL implement two states, IDLE and BUSY.
REQ-013 In IDLE, SHALL drive oreq to all-zero and every iresps[i] to all-zero.
REQ-014 In IDLE with at least one ireqs[i].valid, SHALL select a winner combinationally, register it in owner, and enter BUSY on the next edge (one cycle grant latency).
REQ-015 POLICY=0: winner SHALL be the lowest valid index.
REQ-016 POLICY=1: winner SHALL be the first valid index at or after rr_ptr, searching upward modulo NUM_INPUTS.
REQ-017 In BUSY, SHALL drive oreq = ireqs[owner] and iresps[owner] = oresp, with all other iresps all-zero.
REQ-018 In BUSY, SHALL ignore all non-owner requests; grant is locked for the whole burst.
REQ-019 In BUSY, on a cycle with oresp.ready && oresp.last, SHALL return to IDLE on the next edge.
REQ-020 On that completion edge with POLICY=1, SHALL set rr_ptr = (owner+1) mod NUM_INPUTS, wrapping from NUM_INPUTS-1 to 0.
REQ-021 SHALL never re-arbitrate in the completion cycle; the earliest next grant is registered in the following IDLE cycle.
REQ-022 oresp.ready without last SHALL be forwarded to the owner with no state change; multi-beat bursts are passed through unaltered.
REQ-023 If the owner drops valid while BUSY, SHALL keep forwarding (valid=0) and hold ownership until ready && last; no abort.
REQ-024 busy SHALL equal (state == BUSY); owner SHALL read 0 in IDLE.
REQ-025 Requests present for multiple cycles in IDLE SHALL not be granted twice; a grant is registered only on the IDLE to BUSY transition.

Reset
REQ-026 On a reset cycle, SHALL set state=IDLE, owner=0 and rr_ptr=0, with oreq and all iresps all-zero in the following cycle.
REQ-027 Reset asserted while BUSY SHALL abandon the transaction immediately and take priority over completion.

Structure
REQ-028 cbus_req_t and cbus_resp_t SHALL come from the shared common package; no new types are added to it.
REQ-029 The round-robin winner search SHALL be a sub-module rr_pick (valid vector, pointer in; index and any-valid out), purely combinational.
REQ-030 SHALL be a drop-in replacement for the existing 2-input arbiter, with NUM_INPUTS=2 and POLICY=0 used in the simulation top.

Verification
REQ-031 Single requester: ireqs[1] valid, single beat, with oresp ready+last 3 cycles after the grant; expect busy high for exactly 4 cycles, owner=1, iresps[0] zero throughout.
REQ-032 Round-robin with NUM_INPUTS=4, POLICY=1 and all four requesters continuously valid, each doing one-beat transactions; expect grant order 0,1,2,3,0.
REQ-033 Fixed priority with POLICY=0 and requesters 0 and 2 continuously valid; expect requester 0 to win every arbitration and requester 2 to be starved.
REQ-034 Burst lock: owner 0 issues a 4-beat burst (ready on 4 beats, last on the 4th) while requester 1 raises valid mid-burst; expect owner to stay 0 until the last-beat edge, then requester 1 granted one cycle later.
REQ-035 Reset mid-burst: reset pulsed on beat 2 of owner 3's burst; expect busy=0, owner=0, oreq zero next cycle, and the next round-robin grant searched from index 0.
REQ-036 Wrap: rr_ptr=3 (after owner 2 completes) with only requester 1 valid; expect requester 1 granted and rr_ptr=2 after completion.

Source files
------------

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus request/response types used by the arbiter, its picker and any
// upstream or downstream agents.
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;

    localparam cbus_req_t  CBUS_REQ_IDLE  = '0;
    localparam cbus_resp_t CBUS_RESP_IDLE = '0;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational winner search: first valid index at or after ptr, wrapping
// modulo NUM_INPUTS. A pointer of zero gives plain lowest-index priority.
module rr_pick #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      ptr,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_INPUTS);

    logic [IDX_W:0] cand;

    // Scan from the farthest offset down so the nearest valid index is written last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (valid[cand[IDX_W-1:0]]) begin
                idx = cand[IDX_W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 CBus arbiter: grants one requester for a whole burst (until ready &&
// last), with fixed-priority or round-robin selection between bursts.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int POLICY     = 1,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] owner
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_INPUTS-1:0]   req_valid;
    logic [IDX_W-1:0]        pick_ptr;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    done;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    // Fixed priority is the same search anchored permanently at index 0.
    assign pick_ptr = (POLICY == 1) ? rr_ptr_q : '0;

    rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign done = oresp.ready && oresp.last;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        oreq     = CBUS_REQ_IDLE;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = CBUS_RESP_IDLE;
        end
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    owner_d = pick_idx;
                end
            end
            ST_BUSY: begin
                // Owner is locked; its valid may drop without aborting the burst.
                oreq            = ireqs[owner_q];
                iresps[owner_q] = oresp;
                if (done) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                    if (POLICY == 1) begin
                        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign busy  = (state_q == ST_BUSY);
    assign owner = owner_q;

endmodule
